// File: rtl/avalon_arb_pkg.sv
// Shared types and defaults for the Avalon-MM round-robin master arbiter.
// Imported by the picker and the arbiter top.
package avalon_arb_pkg;

   localparam int          ADDR_W_DEF   = 10;
   localparam int          DATA_W_DEF   = 32;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   // Wait counter width; never zero even with the timeout disabled.
   function automatic int cnt_width(input int t);
      if (t < 1) return 1;
      return $clog2(t + 1);
   endfunction

endpackage

// File: rtl/avalon_rr_master_arbiter_rr_pick.sv
// Round-robin picker: first active request strictly after last_grant.
// Purely combinational.
module rr_pick
   import avalon_arb_pkg::*;
#(
   parameter int N_REQ = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [2:0]       last_grant,
   output logic [2:0]       idx,
   output logic             valid
);

   int c;

   // Walk the rotation backwards so the nearest candidate is written last.
   always_comb begin
      idx   = last_grant;
      valid = 1'b0;
      c     = 0;
      for (int k = N_REQ; k >= 1; k--) begin
         c = (int'(last_grant) + k) % N_REQ;
         if (req[c]) begin
            idx   = 3'(c);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/avalon_rr_master_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port between N requesters.
// One registered transfer per grant, with a sticky waitrequest timeout.
module avalon_rr_master_arbiter
   import avalon_arb_pkg::*;
#(
   parameter int                N_REQ       = 2,
   parameter int                ADDR_W      = ADDR_W_DEF,
   parameter int                DATA_W      = DATA_W_DEF,
   parameter int                TIMEOUT_CYC = 256,
   parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(ERR_DATA_DEF)
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset,
   input  logic [N_REQ*ADDR_W-1:0]   req_address,
   input  logic [N_REQ-1:0]          req_read,
   input  logic [N_REQ-1:0]          req_write,
   input  logic [N_REQ*DATA_W-1:0]   req_writedata,
   output logic [N_REQ-1:0]          req_waitrequest,
   output logic [DATA_W-1:0]         req_readdata,
   output logic [ADDR_W-1:0]         m_address,
   output logic                      m_read,
   output logic                      m_write,
   output logic [DATA_W-1:0]         m_writedata,
   input  logic                      m_waitrequest,
   input  logic [DATA_W-1:0]         m_readdata,
   output logic [2:0]                grant_id,
   output logic                      busy,
   output logic                      timeout_err,
   input  logic                      timeout_clr
);

   localparam int            CW      = cnt_width(TIMEOUT_CYC);
   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYC);

   arb_state_t state;
   arb_state_t state_nxt;

   logic [N_REQ-1:0]  req;
   logic [2:0]        last_grant;
   logic [2:0]        pick_idx;
   logic              pick_vld;
   logic [CW-1:0]     wait_cnt;
   logic              timeout_hit;
   logic              done;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_rd;
   logic              sel_wr;
   logic              issue;

   assign req = req_read | req_write;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_pick (
      .req        (req),
      .last_grant (last_grant),
      .idx        (pick_idx),
      .valid      (pick_vld)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_rd    = 1'b0;
      sel_wr    = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == 3'(i)) begin
            sel_addr  = req_address[i*ADDR_W +: ADDR_W];
            sel_wdata = req_writedata[i*DATA_W +: DATA_W];
            sel_wr    = req_write[i];
            sel_rd    = req_read[i] & ~req_write[i];
         end
      end
   end

   assign issue = (state == IDLE) && pick_vld;

   // Timeout only counts as such while the slave is still stalling.
   assign timeout_hit = (TIMEOUT_CYC != 0) && (state == XFER) &&
                        m_waitrequest && (wait_cnt == CNT_LIM);

   assign done = (state == XFER) && (!m_waitrequest || timeout_hit);

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) state <= IDLE;
      else             state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (pick_vld) state_nxt = XFER;
         XFER: if (done)     state_nxt = IDLE;
         default:            state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy            = (state == XFER);
      req_waitrequest = '1;
      req_readdata    = timeout_hit ? ERR_DATA : m_readdata;
      for (int i = 0; i < N_REQ; i++) begin
         if (done && grant_id == 3'(i)) req_waitrequest[i] = 1'b0;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         m_address   <= '0;
         m_writedata <= '0;
         m_read      <= 1'b0;
         m_write     <= 1'b0;
         grant_id    <= '0;
         last_grant  <= 3'(N_REQ - 1);
      end else if (issue) begin
         m_address   <= sel_addr;
         m_writedata <= sel_wdata;
         m_read      <= sel_rd;
         m_write     <= sel_wr;
         grant_id    <= pick_idx;
         last_grant  <= pick_idx;
      end else if (done) begin
         m_read      <= 1'b0;
         m_write     <= 1'b0;
      end
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         wait_cnt <= '0;
      end else if (state == IDLE) begin
         wait_cnt <= '0;
      end else if (m_waitrequest && wait_cnt != CNT_MAX) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // A timeout in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset)      timeout_err <= 1'b0;
      else if (timeout_hit) timeout_err <= 1'b1;
      else if (timeout_clr) timeout_err <= 1'b0;
   end

endmodule

// File: tb/tb_avalon_rr_master_arbiter.sv
// Scoreboard bench for the Avalon round-robin master arbiter.
// Directed transfers push expectations; a monitor checks each done cycle.
module tb_avalon_rr_master_arbiter;

   localparam int N  = 2;
   localparam int AW = 10;
   localparam int DW = 32;

   logic            clk;
   logic            rst;
   logic [N*AW-1:0] req_address;
   logic [N-1:0]    req_read;
   logic [N-1:0]    req_write;
   logic [N*DW-1:0] req_writedata;
   logic [N-1:0]    req_waitrequest;
   logic [DW-1:0]   req_readdata;
   logic [AW-1:0]   m_address;
   logic            m_read;
   logic            m_write;
   logic [DW-1:0]   m_writedata;
   logic            m_waitrequest;
   logic [DW-1:0]   m_readdata;
   logic [2:0]      grant_id;
   logic            busy;
   logic            timeout_err;
   logic            timeout_clr;

   avalon_rr_master_arbiter #(
      .N_REQ       (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT_CYC (4),
      .ERR_DATA    (32'hDEAD_BEEF)
   ) dut (
      .clk_clk         (clk),
      .reset_reset     (rst),
      .req_address     (req_address),
      .req_read        (req_read),
      .req_write       (req_write),
      .req_writedata   (req_writedata),
      .req_waitrequest (req_waitrequest),
      .req_readdata    (req_readdata),
      .m_address       (m_address),
      .m_read          (m_read),
      .m_write         (m_write),
      .m_writedata     (m_writedata),
      .m_waitrequest   (m_waitrequest),
      .m_readdata      (m_readdata),
      .grant_id        (grant_id),
      .busy            (busy),
      .timeout_err     (timeout_err),
      .timeout_clr     (timeout_clr)
   );

   typedef struct {
      int          id;
      bit          wr;
      logic [9:0]  addr;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   done_q[$];
   int   checks = 0;
   int   errors = 0;
   int   n_done = 0;
   int   cyc    = 0;
   int   slave_wait = 0;
   logic [7:0] scnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave: stalls each command for slave_wait cycles.
   always @(posedge clk or posedge rst) begin
      if (rst)                                     scnt <= '0;
      else if ((m_read | m_write) && m_waitrequest) scnt <= scnt + 8'd1;
      else                                         scnt <= '0;
   end
   assign m_waitrequest = (m_read | m_write) && (int'(scnt) < slave_wait);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input int id, input bit wr, input logic [9:0] a,
                       input logic [31:0] d);
      exp_t e;
      e.id = id; e.wr = wr; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   // Monitor: every done cycle pops one expectation.
   always @(negedge clk) begin
      if (!rst && req_waitrequest != 2'b11) begin
         n_done++;
         done_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            chk("sb_unexpected_done", {61'd0, grant_id}, 64'hFF);
         end else begin
            exp_t e;
            logic [1:0] wm;
            e  = exp_q.pop_front();
            wm = 2'b01 << e.id;
            wm = ~wm;
            chk("sb_grant", grant_id, e.id);
            chk("sb_waitreq", req_waitrequest, wm);
            chk("sb_addr", m_address, e.addr);
            chk("sb_write", m_write, e.wr);
            chk("sb_read", m_read, !e.wr);
            if (e.wr) chk("sb_wdata", m_writedata, e.data);
            else      chk("sb_rdata", req_readdata, e.data);
         end
      end
   end

   task automatic set_req(input int id, input bit rd, input bit wr,
                          input logic [9:0] a, input logic [31:0] d);
      req_read[id]             = rd;
      req_write[id]            = wr;
      req_address[id*AW +: AW] = a;
      req_writedata[id*DW +: DW] = d;
   endtask

   task automatic drop_all();
      req_read  = '0;
      req_write = '0;
   endtask

   task automatic wait_done(input int target);
      int k = 0;
      while (n_done < target && k < 60) begin
         @(negedge clk); #1;
         k++;
      end
      chk("wait_bound", n_done, target);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end");
      $fatal(1);
   end

   initial begin
      int base;
      rst = 1'b1;
      timeout_clr = 1'b0;
      req_address = '0; req_writedata = '0;
      drop_all();
      m_readdata = '0;
      repeat (2) step();
      chk("rst_m_read", m_read, 0);
      chk("rst_m_write", m_write, 0);
      chk("rst_m_address", m_address, 0);
      chk("rst_m_wdata", m_writedata, 0);
      chk("rst_waitreq", req_waitrequest, 2'b11);
      chk("rst_busy", busy, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_grant", grant_id, 0);
      @(posedge clk); #1 rst = 1'b0;

      // 1: single read, two wait cycles
      slave_wait = 2;
      m_readdata = 32'hA5A5_0001;
      push(0, 0, 10'h012, 32'hA5A5_0001);
      @(posedge clk); #1 set_req(0, 1, 0, 10'h012, 0);
      step();
      chk("t1_c0_read", m_read, 0);
      step();
      chk("t1_c1_read", m_read, 1);
      chk("t1_c1_busy", busy, 1);
      chk("t1_c1_wreq", req_waitrequest, 2'b11);
      step();
      chk("t1_c2_read", m_read, 1);
      chk("t1_c2_wreq", req_waitrequest, 2'b11);
      step();
      chk("t1_c3_read", m_read, 1);
      chk("t1_c3_wreq", req_waitrequest, 2'b10);
      @(posedge clk); #1 drop_all();
      step();
      chk("t1_c4_read", m_read, 0);
      chk("t1_c4_busy", busy, 0);

      // 4: read+write on requester 1 is a write
      slave_wait = 0;
      base = n_done;
      push(1, 1, 10'h3FF, 32'hCAFE_F00D);
      @(posedge clk); #1 set_req(1, 1, 1, 10'h3FF, 32'hCAFE_F00D);
      wait_done(base + 1);
      @(posedge clk); #1 drop_all();

      // 2: both requesters write continuously
      base = n_done;
      done_q.delete();
      push(0, 1, 10'h100, 32'h1111_0000);
      push(1, 1, 10'h201, 32'h2222_0001);
      push(0, 1, 10'h100, 32'h1111_0000);
      push(1, 1, 10'h201, 32'h2222_0001);
      @(posedge clk); #1;
      set_req(0, 0, 1, 10'h100, 32'h1111_0000);
      set_req(1, 0, 1, 10'h201, 32'h2222_0001);
      wait_done(base + 4);
      @(posedge clk); #1 drop_all();
      if (done_q.size() == 4) begin
         for (int i = 1; i < 4; i++)
            chk("t2_period", done_q[i] - done_q[i-1], 2);
      end else begin
         chk("t2_done_count", done_q.size(), 4);
      end

      // 3: timeout with a stalled slave
      slave_wait = 255;
      m_readdata = 32'h0BAD_0000;
      push(0, 0, 10'h055, 32'hDEAD_BEEF);
      @(posedge clk); #1 set_req(0, 1, 0, 10'h055, 0);
      repeat (5) step();
      chk("t3_c4_wreq", req_waitrequest, 2'b11);
      step();
      chk("t3_c5_wreq", req_waitrequest, 2'b10);
      chk("t3_c5_err", timeout_err, 0);
      @(posedge clk); #1 drop_all();
      step();
      chk("t3_err_set", timeout_err, 1);
      repeat (2) step();
      chk("t3_err_sticky", timeout_err, 1);
      @(posedge clk); #1 timeout_clr = 1'b1;
      @(posedge clk); #1 timeout_clr = 1'b0;
      step();
      chk("t3_err_cleared", timeout_err, 0);
      base = n_done;
      timeout_clr = 1'b1;
      push(0, 0, 10'h056, 32'hDEAD_BEEF);
      @(posedge clk); #1 set_req(0, 1, 0, 10'h056, 0);
      wait_done(base + 1);
      @(posedge clk); #1 drop_all();
      step();
      chk("t3_set_wins", timeout_err, 1);
      timeout_clr = 1'b1;
      @(posedge clk); #1 timeout_clr = 1'b0;
      step();
      chk("t3_err_cleared2", timeout_err, 0);

      // 6: requester 0 drops strobe mid-transfer
      slave_wait = 2;
      m_readdata = 32'h6666_0006;
      base = n_done;
      push(0, 0, 10'h066, 32'h6666_0006);
      @(posedge clk); #1 set_req(0, 1, 0, 10'h066, 0);
      @(posedge clk); #1 drop_all();
      step();
      chk("t6_read_held", m_read, 1);
      wait_done(base + 1);
      slave_wait = 0;
      m_readdata = 32'h7777_0007;
      base = n_done;
      push(1, 0, 10'h171, 32'h7777_0007);
      push(0, 0, 10'h070, 32'h7777_0007);
      set_req(0, 1, 0, 10'h070, 0);
      set_req(1, 1, 0, 10'h171, 0);
      wait_done(base + 2);
      @(posedge clk); #1 drop_all();

      // 5: asynchronous reset mid-transfer
      slave_wait = 255;
      @(posedge clk); #1 set_req(0, 1, 0, 10'h0AA, 0);
      repeat (3) step();
      chk("t5_read_before", m_read, 1);
      #3 rst = 1'b1;
      #1;
      chk("t5_read_async", m_read, 0);
      chk("t5_write_async", m_write, 0);
      chk("t5_busy_async", busy, 0);
      chk("t5_wreq_async", req_waitrequest, 2'b11);
      drop_all();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      slave_wait = 0;
      base = n_done;
      push(0, 1, 10'h0B0, 32'h5555_0000);
      push(1, 1, 10'h1B1, 32'h5555_0001);
      set_req(0, 0, 1, 10'h0B0, 32'h5555_0000);
      set_req(1, 0, 1, 10'h1B1, 32'h5555_0001);
      wait_done(base + 2);
      @(posedge clk); #1 drop_all();
      repeat (3) step();

      chk("sb_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
